// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcode encodings and
// opcode classification helpers used by the ID/EX stage.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RIDX = 5;
  localparam int OPW  = 5;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00010;
  localparam logic [OPW-1:0] OP_ADDI = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_SUBI = 5'b00101;
  localparam logic [OPW-1:0] OP_AND  = 5'b01010;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01011;
  localparam logic [OPW-1:0] OP_OR   = 5'b01100;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OP_NOT  = 5'b01110;
  localparam logic [OPW-1:0] OP_XOR  = 5'b10000;
  localparam logic [OPW-1:0] OP_XORI = 5'b10001;
  localparam logic [OPW-1:0] OP_BEQ  = 5'b11000;
  localparam logic [OPW-1:0] OP_BNE  = 5'b11001;
  localparam logic [OPW-1:0] OP_BLT  = 5'b11010;

  // Opcodes whose second ALU operand is the decoded immediate.
  function automatic logic is_imm(input logic [OPW-1:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI};
  endfunction

  // NOT and the immediate forms never read rs2, so rs2 cannot stall them.
  function automatic logic uses_rs2(input logic [OPW-1:0] op);
    return !is_imm(op) && (op != OP_NOT);
  endfunction

  // Branches compare only; everything else writes its destination.
  function automatic logic writes_rd(input logic [OPW-1:0] op);
    return !(op inside {OP_BEQ, OP_BNE, OP_BLT});
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Single-operand source select for the ID/EX stage. Register 0 always
// reads as zero. With ID_EX_FWD_EN defined, a non-load EX/MEM result has
// priority over a MEM/WB result, which has priority over the register file;
// without it the register-file value is used and the stage stalls instead.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [RIDX-1:0] rs,
  input  logic [XLEN-1:0] rf_val,
  input  logic            exm_wr_en,
  input  logic            exm_is_load,
  input  logic [RIDX-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_val,
  input  logic            mwb_wr_en,
  input  logic [RIDX-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_val,
  output logic [XLEN-1:0] val
);

`ifdef ID_EX_FWD_EN
  // Priority forward select; a load in EX/MEM has no data yet, so it is skipped.
  always_comb begin
    val = rf_val;
    if (rs == '0)
      val = '0;
    else if (exm_wr_en && !exm_is_load && (exm_rd == rs))
      val = exm_val;
    else if (mwb_wr_en && (mwb_rd == rs))
      val = mwb_val;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm_wr_en, exm_is_load, exm_rd, exm_val,
                        mwb_wr_en, mwb_rd, mwb_val};

  // Register-file value only, with the zero-register rule.
  always_comb begin
    val = rf_val;
    if (rs == '0)
      val = '0;
  end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 32-bit ALU. Captures decoded
// instructions over a valid/ready handshake, resolves operands (forwarding
// when ID_EX_FWD_EN is defined, stalling on any pending writer otherwise),
// inserts load-use bubbles and squashes on flush.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [OPW-1:0]  dec_opcode,
  input  logic [RIDX-1:0] dec_rs1,
  input  logic [RIDX-1:0] dec_rs2,
  input  logic [RIDX-1:0] dec_rd,
  input  logic [XLEN-1:0] dec_rs1_val,
  input  logic [XLEN-1:0] dec_rs2_val,
  input  logic [XLEN-1:0] dec_imm,
  input  logic            exm_wr_en,
  input  logic            exm_is_load,
  input  logic [RIDX-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_val,
  input  logic            mwb_wr_en,
  input  logic [RIDX-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_val,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [OPW-1:0]  alu_opcode,
  output logic [RIDX-1:0] ex_rd,
  output logic            ex_wr_en
);

  logic            use_rs1;
  logic            use_rs2;
  logic            hazard;
  logic            advance;
  logic            accept;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] opnd_b;

  logic            vld_p0;
  logic [XLEN-1:0] a_p0;
  logic [XLEN-1:0] b_p0;
  logic [OPW-1:0]  op_p0;
  logic [RIDX-1:0] rd_p0;
  logic            wr_p0;

  // Register 0 is never a dependency, whatever writes it.
  assign use_rs1 = (dec_rs1 != '0);
  assign use_rs2 = uses_rs2(dec_opcode) && (dec_rs2 != '0);

  // Stall detection for the instruction offered by decode.
  always_comb begin
    hazard = 1'b0;
`ifdef ID_EX_FWD_EN
    if (exm_wr_en && exm_is_load) begin
      if (use_rs1 && (exm_rd == dec_rs1)) hazard = 1'b1;
      if (use_rs2 && (exm_rd == dec_rs2)) hazard = 1'b1;
    end
`else
    if (use_rs1 && ((exm_wr_en && (exm_rd == dec_rs1)) ||
                    (mwb_wr_en && (mwb_rd == dec_rs1))))
      hazard = 1'b1;
    if (use_rs2 && ((exm_wr_en && (exm_rd == dec_rs2)) ||
                    (mwb_wr_en && (mwb_rd == dec_rs2))))
      hazard = 1'b1;
`endif
  end

  // The slot frees when it is empty or the ALU takes it this cycle; flush
  // always lets decode move on, but what it offers is dropped.
  assign advance   = !vld_p0 || ex_ready;
  assign dec_ready = flush || (advance && !hazard);
  assign accept    = dec_valid && dec_ready && !flush;

  fwd_mux u_fwd_a (
    .rs          (dec_rs1),
    .rf_val      (dec_rs1_val),
    .exm_wr_en   (exm_wr_en),
    .exm_is_load (exm_is_load),
    .exm_rd      (exm_rd),
    .exm_val     (exm_val),
    .mwb_wr_en   (mwb_wr_en),
    .mwb_rd      (mwb_rd),
    .mwb_val     (mwb_val),
    .val         (fwd_a)
  );

  fwd_mux u_fwd_b (
    .rs          (dec_rs2),
    .rf_val      (dec_rs2_val),
    .exm_wr_en   (exm_wr_en),
    .exm_is_load (exm_is_load),
    .exm_rd      (exm_rd),
    .exm_val     (exm_val),
    .mwb_wr_en   (mwb_wr_en),
    .mwb_rd      (mwb_rd),
    .mwb_val     (mwb_val),
    .val         (fwd_b)
  );

  // Second operand: immediate for I-type, zero for NOT, else the rs2 source.
  always_comb begin
    opnd_b = fwd_b;
    if (is_imm(dec_opcode))
      opnd_b = dec_imm;
    else if (dec_opcode == OP_NOT)
      opnd_b = '0;
  end

  // ---- ID -> EX boundary: capture, hold, bubble or squash ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      a_p0   <= '0;
      b_p0   <= '0;
      op_p0  <= '0;
      rd_p0  <= '0;
      wr_p0  <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= accept;
      if (accept) begin
        a_p0  <= fwd_a;
        b_p0  <= opnd_b;
        op_p0 <= dec_opcode;
        rd_p0 <= dec_rd;
        wr_p0 <= writes_rd(dec_opcode);
      end
    end
  end

  assign ex_valid   = vld_p0;
  assign alu_a      = a_p0;
  assign alu_b      = b_p0;
  assign alu_opcode = op_p0;
  assign ex_rd      = rd_p0;
  assign ex_wr_en   = wr_p0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by a
// randomized run against a cycle-level reference model. Expectations follow
// ID_EX_FWD_EN the same way the design does.
module tb_id_ex_stage;

  localparam logic [4:0] ADD  = 5'b00010, ADDI = 5'b00011, SUB = 5'b00100;
  localparam logic [4:0] SUBI = 5'b00101, AND_ = 5'b01010, ANDI = 5'b01011;
  localparam logic [4:0] OR_  = 5'b01100, ORI  = 5'b01101, NOT_ = 5'b01110;
  localparam logic [4:0] XOR_ = 5'b10000, XORI = 5'b10001, BEQ  = 5'b11000;
  localparam logic [4:0] BNE  = 5'b11001, BLT  = 5'b11010;

  logic        clk, rst, flush, dec_valid, dec_ready;
  logic [4:0]  dec_opcode, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_rs1_val, dec_rs2_val, dec_imm;
  logic        exm_wr_en, exm_is_load;
  logic [4:0]  exm_rd;
  logic [31:0] exm_val;
  logic        mwb_wr_en;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_val;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_opcode, ex_rd;
  logic        ex_wr_en;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val), .dec_imm(dec_imm),
    .exm_wr_en(exm_wr_en), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_val(exm_val),
    .mwb_wr_en(mwb_wr_en), .mwb_rd(mwb_rd), .mwb_val(mwb_val),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers (stimulus / expectation building only) ----------
  function automatic logic [75:0] bundle(input logic v, input logic [31:0] a,
      input logic [31:0] b, input logic [4:0] op, input logic [4:0] rd, input logic wr);
    return {v, a, b, op, rd, wr};
  endfunction

  function automatic logic [75:0] outs();
    return {ex_valid, alu_a, alu_b, alu_opcode, ex_rd, ex_wr_en};
  endfunction

  task automatic idle();
    flush = 0; dec_valid = 0; dec_opcode = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_rs1_val = 0; dec_rs2_val = 0; dec_imm = 0;
    exm_wr_en = 0; exm_is_load = 0; exm_rd = 0; exm_val = 0;
    mwb_wr_en = 0; mwb_rd = 0; mwb_val = 0; ex_ready = 1;
  endtask

  task automatic offer(input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
      input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm);
    dec_valid = 1; dec_opcode = op; dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd;
    dec_rs1_val = v1; dec_rs2_val = v2; dec_imm = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    idle(); rst = 1;
    offer(ADD, 1, 2, 3, 32'h11, 32'h22, 0);
    tick();
    checks++; if (outs() !== '0) begin errors++; $display("FAIL reset_outs got %h want 0", outs()); end
    tick();
    checks++; if (outs() !== '0) begin errors++; $display("FAIL reset_hold got %h want 0", outs()); end
    rst = 0; idle();
    tick();
  endtask

  task automatic test_add();
    idle(); offer(ADD, 1, 2, 3, 5, 7, 0);
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b want 1", dec_ready); end
    tick();
    checks++; if (outs() !== bundle(1, 5, 7, ADD, 3, 1)) begin errors++; $display("FAIL add_out got %h want %h", outs(), bundle(1, 5, 7, ADD, 3, 1)); end
    dec_valid = 0;
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", ex_valid); end
  endtask

  task automatic test_fwd_priority();
    idle(); offer(ADDI, 4, 9, 10, 32'h99, 32'h77, 32'hFFFF_FFFF);
    exm_wr_en = 1; exm_rd = 4; exm_val = 32'h10;
    mwb_wr_en = 1; mwb_rd = 4; mwb_val = 32'h20;
    #1;
`ifdef ID_EX_FWD_EN
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready got %b want 1", dec_ready); end
    tick();
    checks++; if (outs() !== bundle(1, 32'h10, 32'hFFFF_FFFF, ADDI, 10, 1)) begin errors++; $display("FAIL fwd_prio got %h want %h", outs(), bundle(1, 32'h10, 32'hFFFF_FFFF, ADDI, 10, 1)); end
`else
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL nofwd_stall got %b want 0", dec_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL nofwd_bubble got %b want 0", ex_valid); end
    exm_wr_en = 0; #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL nofwd_mwb_stall got %b want 0", dec_ready); end
    mwb_wr_en = 0; #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL nofwd_clear got %b want 1", dec_ready); end
    tick();
    checks++; if (outs() !== bundle(1, 32'h99, 32'hFFFF_FFFF, ADDI, 10, 1)) begin errors++; $display("FAIL nofwd_rf got %h want %h", outs(), bundle(1, 32'h99, 32'hFFFF_FFFF, ADDI, 10, 1)); end
`endif
  endtask

  task automatic test_load_use();
    idle(); offer(ADD, 1, 2, 9, 1, 2, 0);
    tick();
    offer(SUB, 6, 1, 7, 32'h111, 32'h3, 0);
    exm_wr_en = 1; exm_is_load = 1; exm_rd = 6; exm_val = 32'hBAD;
    #1;
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got %b want 0", dec_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b want 0", ex_valid); end
    exm_wr_en = 0; exm_is_load = 0; mwb_wr_en = 1; mwb_rd = 6; mwb_val = 32'h55;
    #1;
`ifdef ID_EX_FWD_EN
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL lu_ready got %b want 1", dec_ready); end
    tick();
    checks++; if (outs() !== bundle(1, 32'h55, 3, SUB, 7, 1)) begin errors++; $display("FAIL lu_mwb got %h want %h", outs(), bundle(1, 32'h55, 3, SUB, 7, 1)); end
`else
    checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL lu_mwb_stall got %b want 0", dec_ready); end
    tick();
    mwb_wr_en = 0; #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL lu_ready got %b want 1", dec_ready); end
    tick();
    checks++; if (outs() !== bundle(1, 32'h111, 3, SUB, 7, 1)) begin errors++; $display("FAIL lu_rf got %h want %h", outs(), bundle(1, 32'h111, 3, SUB, 7, 1)); end
`endif
  endtask

  task automatic test_hold();
    logic [75:0] held;
    idle(); offer(ADD, 1, 2, 5, 32'hA, 32'hB, 0);
    tick();
    held = bundle(1, 32'hA, 32'hB, ADD, 5, 1);
    ex_ready = 0; offer(OR_, 1, 2, 8, 32'h1, 32'h2, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b want 0", i, dec_ready); end
      tick();
      checks++; if (outs() !== held) begin errors++; $display("FAIL hold_stable[%0d] got %h want %h", i, outs(), held); end
    end
    ex_ready = 1; #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %b want 1", dec_ready); end
    tick();
    checks++; if (outs() !== bundle(1, 1, 2, OR_, 8, 1)) begin errors++; $display("FAIL hold_next got %h want %h", outs(), bundle(1, 1, 2, OR_, 8, 1)); end
  endtask

  task automatic test_flush();
    idle(); offer(ADD, 1, 2, 5, 32'hA, 32'hB, 0);
    tick();
    ex_ready = 0; offer(XOR_, 1, 2, 12, 3, 4, 0); flush = 1;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", dec_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_squash got %b want 0", ex_valid); end
    flush = 0; dec_valid = 0; ex_ready = 1;
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got %b want 0", ex_valid); end
  endtask

  task automatic test_special_ops();
    idle(); offer(ADD, 0, 2, 3, 32'h1234, 7, 0);
    exm_wr_en = 1; exm_rd = 0; exm_val = 32'hDEAD;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got %b want 1", dec_ready); end
    tick();
    checks++; if (outs() !== bundle(1, 0, 7, ADD, 3, 1)) begin errors++; $display("FAIL x0_zero got %h want %h", outs(), bundle(1, 0, 7, ADD, 3, 1)); end
    idle(); offer(NOT_, 3, 4, 6, 32'h5, 32'h9, 32'h77);
    exm_wr_en = 1; exm_is_load = 1; exm_rd = 4;
    #1;
    checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL not_ready got %b want 1", dec_ready); end
    tick();
    checks++; if (outs() !== bundle(1, 5, 0, NOT_, 6, 1)) begin errors++; $display("FAIL not_out got %h want %h", outs(), bundle(1, 5, 0, NOT_, 6, 1)); end
    idle(); offer(BEQ, 1, 2, 3, 32'h42, 32'h43, 0);
    tick();
    checks++; if (outs() !== bundle(1, 32'h42, 32'h43, BEQ, 3, 0)) begin errors++; $display("FAIL beq_out got %h want %h", outs(), bundle(1, 32'h42, 32'h43, BEQ, 3, 0)); end
  endtask

  task automatic test_reset_mid_hold();
    idle(); offer(ADD, 1, 2, 5, 32'hA, 32'hB, 0);
    tick();
    ex_ready = 0; dec_valid = 0;
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rmh_held got %b want 1", ex_valid); end
    #2 rst = 1;
    #1;
    checks++; if (outs() !== '0) begin errors++; $display("FAIL rmh_async got %h want 0", outs()); end
    #1 rst = 0;
    idle();
    tick();
  endtask

  // ---------------- randomized run against reference model ----------------
  logic        m_vld, m_wr;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_op, m_rd;

  function automatic logic [4:0] pick_op(input int i);
    case (i)
      0: return ADD;   1: return ADDI;  2: return SUB;  3: return SUBI;
      4: return AND_;  5: return ANDI;  6: return OR_;  7: return ORI;
      8: return NOT_;  9: return XOR_; 10: return XORI; 11: return BEQ;
      12: return BNE;  default: return BLT;
    endcase
  endfunction

  function automatic logic model_imm(input logic [4:0] op);
    return op == ADDI || op == SUBI || op == ANDI || op == ORI || op == XORI;
  endfunction

  // Value a source register yields given the writers in flight.
  function automatic logic [31:0] model_src(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 0;
`ifdef ID_EX_FWD_EN
    if (exm_wr_en && !exm_is_load && exm_rd == r) return exm_val;
    if (mwb_wr_en && mwb_rd == r) return mwb_val;
`endif
    return rf;
  endfunction

  // True when register r cannot be read yet.
  function automatic logic model_blocked(input logic [4:0] r);
    if (r == 0) return 0;
`ifdef ID_EX_FWD_EN
    return exm_wr_en && exm_is_load && exm_rd == r;
`else
    return (exm_wr_en && exm_rd == r) || (mwb_wr_en && mwb_rd == r);
`endif
  endfunction

  function automatic logic model_ready();
    logic stall;
    stall = model_blocked(dec_rs1);
    if (!model_imm(dec_opcode) && dec_opcode != NOT_) stall = stall || model_blocked(dec_rs2);
    return flush || ((!m_vld || ex_ready) && !stall);
  endfunction

  task automatic test_random();
    logic exp_rdy;
    idle();
    tick();
    m_vld = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_wr = 0;
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 19) == 0);
      ex_ready  = ($urandom_range(0, 3) != 0);
      dec_valid = ($urandom_range(0, 9) < 7);
      dec_opcode = pick_op($urandom_range(0, 13));
      dec_rs1 = 5'($urandom_range(0, 7)); dec_rs2 = 5'($urandom_range(0, 7));
      dec_rd  = 5'($urandom_range(0, 7));
      dec_rs1_val = $urandom; dec_rs2_val = $urandom; dec_imm = $urandom;
      if (ex_ready) begin
        exm_wr_en = 1'($urandom_range(0, 1)); exm_is_load = ($urandom_range(0, 2) == 0);
        exm_rd = 5'($urandom_range(0, 7)); exm_val = $urandom;
        mwb_wr_en = 1'($urandom_range(0, 1)); mwb_rd = 5'($urandom_range(0, 7)); mwb_val = $urandom;
      end
      #1;
      exp_rdy = model_ready();
      checks++; if (dec_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", n, dec_ready, exp_rdy); end
      if (flush) m_vld = 0;
      else if (!m_vld || ex_ready) begin
        m_vld = dec_valid && exp_rdy;
        if (m_vld) begin
          m_a  = model_src(dec_rs1, dec_rs1_val);
          m_b  = model_imm(dec_opcode) ? dec_imm :
                 (dec_opcode == NOT_) ? 32'h0 : model_src(dec_rs2, dec_rs2_val);
          m_op = dec_opcode; m_rd = dec_rd;
          m_wr = !(dec_opcode == BEQ || dec_opcode == BNE || dec_opcode == BLT);
        end
      end
      tick();
      checks++;
      if (ex_valid !== m_vld) begin
        errors++; $display("FAIL rnd_valid[%0d] got %b want %b", n, ex_valid, m_vld);
      end else if (m_vld && outs() !== bundle(m_vld, m_a, m_b, m_op, m_rd, m_wr)) begin
        errors++; $display("FAIL rnd_data[%0d] got %h want %h", n, outs(), bundle(m_vld, m_a, m_b, m_op, m_rd, m_wr));
      end
    end
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_add();
    test_fwd_priority();
    test_load_use();
    test_hold();
    test_flush();
    test_special_ops();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the 32-bit ALU.
- Accepts decoded instructions with a valid/ready handshake, resolves operand forwarding from the EX/MEM and MEM/WB stages, and selects the immediate for I-type opcodes.
- Inserts load-use bubbles, supports flush on branch mispredict, and presents registered a/b/opcode to the ALU.

Parameters:
- XLEN, 32, datapath width of operands and immediate.
- RIDX, 5, register index width; register 0 is hardwired zero.
- OPW, 5, opcode width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  squash held and incoming instruction
- dec_valid  in  1  decode presents an instruction
- dec_ready  out  1  stage accepts this cycle
- dec_opcode  in  OPW  opcode
- dec_rs1, dec_rs2, dec_rd  in  RIDX each  source and destination indices
- dec_rs1_val, dec_rs2_val  in  XLEN each  register-file read data
- dec_imm  in  XLEN  sign-extended immediate
- exm_wr_en  in  1  EX/MEM will write exm_rd
- exm_is_load  in  1  EX/MEM instruction is a load (data not yet available)
- exm_rd  in  RIDX  EX/MEM destination
- exm_val  in  XLEN  EX/MEM result
- mwb_wr_en  in  1  MEM/WB writes mwb_rd
- mwb_rd  in  RIDX  MEM/WB destination
- mwb_val  in  XLEN  MEM/WB result
- ex_valid  out  1  ALU inputs valid
- ex_ready  in  1  downstream accepts
- alu_a, alu_b  out  XLEN each  ALU operands
- alu_opcode  out  OPW  ALU opcode
- ex_rd  out  RIDX  destination carried forward
- ex_wr_en  out  1  instruction writes ex_rd; 0 for branch opcodes

Behaviour:
- Reset, asynchronous: every output register is 0, including ex_valid, alu_a, alu_b, alu_opcode, ex_rd and ex_wr_en. dec_ready is combinational.
- Handshake: transfer when dec_valid && dec_ready. Downstream is held while ex_valid && !ex_ready. Outputs are stable while held.
- Capture latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N.
- Immediate opcodes: 00011, 00101, 01011, 01101, 10001 (ADDI, SUBI, ANDI, ORI, XORI).
  - For these, alu_b = dec_imm and rs2 is not a hazard source.
  - NOT (01110): alu_b = 0; rs2 is unused.
- Forwarding at capture, per source whose index is nonzero, in priority order:
  1. exm_wr_en && exm_rd == rs && !exm_is_load → exm_val
  2. else mwb_wr_en && mwb_rd == rs → mwb_val
  3. else register-file value
- Register index 0 always yields 0.
- Load-use hazard: exm_is_load && exm_wr_en && exm_rd == a used nonzero source.
  - dec_ready = 0 for that cycle.
  - If the held slot advances, ex_valid drops (bubble). Otherwise the held instruction stays.
- dec_ready = (!ex_valid || ex_ready) && !hazard, or 1 when flush = 1.
- Flush takes priority over both capture and hold. The cycle after flush, ex_valid = 0, and the instruction offered during flush is discarded.
- Frozen sources: exm_* and mwb_* are frozen whenever ex_ready = 0. This is a system contract, so no re-forwarding is needed while holding.
- Simultaneous accept and advance in one cycle loads the new instruction, giving full throughput.
- Reset mid-hold clears the slot immediately, asynchronously.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: the forwarding network above.
- Undefined:
  - No forwarding muxes; operands always come from the register file.
  - Any nonzero used source matching exm_rd (exm_wr_en) or mwb_rd (mwb_wr_en) is a hazard and forces dec_ready = 0 until it clears.
  - Flush and immediate rules are unchanged.

Decomposition:
- cpu_pkg holds:
  - opcode localparams ADD..XORI and branch opcodes
  - XLEN, RIDX, OPW
  - function is_imm(opcode)
  - function uses_rs2(opcode)
  - function writes_rd(opcode)
- Sub-module fwd_mux holds the single-operand priority forward select plus the zero-register rule. It is instantiated twice.

Test Plan:
- ADD x3 ← x1,x2 with rs1_val=5, rs2_val=7, no writers → next cycle ex_valid=1, alu_a=5, alu_b=7, alu_opcode=00010, ex_rd=3.
- ADDI rs1=4, imm=0xFFFFFFFF, exm writes x4=0x10, mwb writes x4=0x20 → alu_a=0x10 (EX/MEM wins), alu_b=0xFFFFFFFF.
- exm_is_load on x6, decode SUB x7 ← x6,x1 → dec_ready=0 for one cycle and a bubble goes out; the cycle after, accepted with alu_a=mwb_val.
- ex_ready=0 for 3 cycles with dec_valid=1 → outputs stable and dec_ready=0; ex_ready=1 → new instruction loaded on the next edge.
- flush asserted while holding and dec_valid=1 → next cycle ex_valid=0, and the offered instruction never appears.
- rs1=0 with exm writing x0=0xDEAD → alu_a=0; rst pulsed mid-hold → all outputs 0 immediately.
